// File: rtl/reg_file.sv
// General-purpose register file: one write port, two bypassed async read ports, and a register dump engine.
// Latency: writes land 1 cycle after reg_write; reads and dump_data are combinational with write-first bypass.
// Backpressure: a dump beat holds dump_idx while dump_ready is low; dump_valid/busy/done come from the state register only.
module reg_file #(
    parameter int NREGS = 32,
    parameter int WIDTH = 16,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             reg_write,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             dump_req,
    output logic             dump_busy,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [AW-1:0]    dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [WIDTH-1:0] regs [NREGS];
    dump_state_t      state;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write) begin
            regs[waddr] <= wdata;
        end
    end

    // Write-first bypass closes the writeback-to-decode hazard; the dump port shares it.
    always_comb begin
        rdata_a   = (reg_write && waddr == raddr_a)  ? wdata : regs[raddr_a];
        rdata_b   = (reg_write && waddr == raddr_b)  ? wdata : regs[raddr_b];
        dump_data = (reg_write && waddr == dump_idx) ? wdata : regs[dump_idx];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            dump_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state    <= SCAN;
                        dump_idx <= '0;
                    end
                end
                SCAN: begin
                    if (dump_ready) begin
                        if (dump_idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            dump_idx <= dump_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    dump_idx <= '0;
                end
                default: begin
                    state    <= IDLE;
                    dump_idx <= '0;
                end
            endcase
        end
    end

    assign dump_busy  = (state == SCAN) || (state == DONE);
    assign dump_valid = (state == SCAN);
    assign dump_done  = (state == DONE);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, bypass, clear priority, dump with and without backpressure, abort.
module tb_reg_file;

    localparam int NREGS = 32;
    localparam int WIDTH = 16;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             clr;
    logic             reg_write;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic             dump_req;
    logic             dump_busy;
    logic             dump_valid;
    logic             dump_ready;
    logic [AW-1:0]    dump_idx;
    logic [WIDTH-1:0] dump_data;
    logic             dump_done;

    int n_total = 0;
    int n_bad   = 0;

    logic [WIDTH-1:0] model [NREGS];

    reg_file #(.NREGS(NREGS), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .clr        (clr),
        .reg_write  (reg_write),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr_a    (raddr_a),
        .rdata_a    (rdata_a),
        .raddr_b    (raddr_b),
        .rdata_b    (rdata_b),
        .dump_req   (dump_req),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        reg_write = 1'b1;
        waddr     = a;
        wdata     = d;
        tick();
        reg_write = 1'b0;
    endtask

    initial begin
        int  exp_idx;
        int  cyc;
        bit  got_done;
        bit  wrote;

        clr = 1'b1; reg_write = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; dump_req = 1'b0; dump_ready = 1'b0;
        tick();
        tick();
        clr = 1'b0;

        // Reset clears storage and the dump engine
        wr(5'd7, 16'h1234);
        raddr_a = 5'd7; #1;
        check("pre_clr_r7", 32'(rdata_a), 32'h1234);
        clr = 1'b1; tick(); clr = 1'b0; #1;
        check("rst_r7", 32'(rdata_a), 32'h0000);
        check("rst_busy", 32'(dump_busy), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_idx", 32'(dump_idx), 32'd0);

        // Write then read on both ports, including r0
        wr(5'd3, 16'hBEEF);
        raddr_a = 5'd3; raddr_b = 5'd3; #1;
        check("rd_a_r3", 32'(rdata_a), 32'hBEEF);
        check("rd_b_r3", 32'(rdata_b), 32'hBEEF);
        wr(5'd0, 16'h00FF);
        raddr_a = 5'd0; raddr_b = 5'd3; #1;
        check("rd_a_r0", 32'(rdata_a), 32'h00FF);
        check("rd_b_r3_again", 32'(rdata_b), 32'hBEEF);

        // Same-cycle write bypass
        wr(5'd5, 16'h0001);
        raddr_a = 5'd5; raddr_b = 5'd5; #1;
        check("r5_stored", 32'(rdata_a), 32'h0001);
        reg_write = 1'b1; waddr = 5'd5; wdata = 16'hA5A5; raddr_b = 5'd3; #1;
        check("bypass_a", 32'(rdata_a), 32'hA5A5);
        check("no_bypass_b", 32'(rdata_b), 32'hBEEF);
        tick(); reg_write = 1'b0; #1;
        check("r5_after", 32'(rdata_a), 32'hA5A5);

        // clr wins over a coincident write
        clr = 1'b1; reg_write = 1'b1; waddr = 5'd2; wdata = 16'h7777;
        tick();
        clr = 1'b0; reg_write = 1'b0; raddr_a = 5'd2; raddr_b = 5'd5; #1;
        check("clr_prio_r2", 32'(rdata_a), 32'h0000);
        check("clr_r5", 32'(rdata_b), 32'h0000);

        // Full dump, consumer always ready
        for (int i = 0; i < NREGS; i++) begin
            model[i] = 16'h0100 + 16'(i);
            wr(AW'(i), model[i]);
        end
        dump_ready = 1'b1; dump_req = 1'b1;
        tick();
        dump_req = 1'b0; #1;
        for (int i = 0; i < NREGS; i++) begin
            check("full_valid", 32'(dump_valid), 32'd1);
            check("full_idx", 32'(dump_idx), 32'(i));
            check("full_data", 32'(dump_data), 32'h0100 + 32'(i));
            tick();
        end
        check("full_done", 32'(dump_done), 32'd1);
        check("full_done_busy", 32'(dump_busy), 32'd1);
        check("full_done_valid", 32'(dump_valid), 32'd0);
        tick();
        check("full_done_pulse", 32'(dump_done), 32'd0);
        check("full_idle_busy", 32'(dump_busy), 32'd0);
        check("full_idle_idx", 32'(dump_idx), 32'd0);

        // Dump with ready pattern 1,0,0,1 repeating; write the stalled index once; stray dump_req mid-dump
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        exp_idx = 0; cyc = 0; got_done = 1'b0; wrote = 1'b0;
        while (!got_done && cyc < 400) begin
            dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            dump_req   = (cyc == 7);
            reg_write  = 1'b0;
            if (!dump_ready && exp_idx == 5 && !wrote) begin
                reg_write = 1'b1; waddr = 5'd5; wdata = 16'hCAFE;
                model[5] = 16'hCAFE; wrote = 1'b1;
            end
            #1;
            if (dump_done) begin
                got_done = 1'b1;
            end else begin
                check("bp_valid", 32'(dump_valid), 32'd1);
                check("bp_idx", 32'(dump_idx), 32'(exp_idx));
                check("bp_data", 32'(dump_data), 32'(model[exp_idx[AW-1:0]]));
                if (dump_ready) exp_idx++;
            end
            tick();
            cyc++;
        end
        reg_write = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
        check("bp_got_done", 32'(got_done), 32'd1);
        check("bp_beats", 32'(exp_idx), 32'(NREGS));
        check("bp_idle_busy", 32'(dump_busy), 32'd0);
        tick();
        check("bp_no_restart", 32'(dump_valid), 32'd0);

        // Abort at index 10
        dump_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_pre_idx", 32'(dump_idx), 32'd10);
        check("abort_pre_valid", 32'(dump_valid), 32'd1);
        clr = 1'b1; tick(); clr = 1'b0; dump_ready = 1'b0;
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_busy", 32'(dump_busy), 32'd0);
        check("abort_idx", 32'(dump_idx), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", 32'(dump_done), 32'd0);
            tick();
        end
        for (int i = 0; i < NREGS; i++) begin
            raddr_a = AW'(i); #1;
            check("abort_zero", 32'(rdata_a), 32'h0000);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the 16-bit pipelined core. It is the receiving end of the writeback stage's write port (reg_write/addr/Z5).
- Provides two asynchronous read ports with same-cycle write bypass to the decode/operand stage.
- Includes a sequential dump engine that streams every register out over a valid/ready channel, for debug and state-dump support.

Parameters:
NREGS, 32, number of registers (power of two)
WIDTH, 16, register data width
AW, 5, register address width (log2 NREGS)

Ports:
clk  input  1  clock, all state updates on rising edge
clr  input  1  synchronous active-high reset (clear)
reg_write  input  1  write enable from writeback stage
waddr  input  AW  write address from writeback stage
wdata  input  WIDTH  write data from writeback stage
raddr_a  input  AW  read port A address
rdata_a  output  WIDTH  read port A data
raddr_b  input  AW  read port B address
rdata_b  output  WIDTH  read port B data
dump_req  input  1  start a full-register dump (sampled only when idle)
dump_busy  output  1  dump engine active (SCAN or DONE)
dump_valid  output  1  dump_idx/dump_data valid this cycle
dump_ready  input  1  consumer accepts current dump beat
dump_idx  output  AW  index of register being dumped
dump_data  output  WIDTH  contents of register dump_idx
dump_done  output  1  one-cycle pulse after last beat accepted

Behaviour:

Reset:
- One clock, clk. Reset clr is synchronous and active-high.
- clr high at a rising edge: all NREGS registers <= 0; FSM <= IDLE; dump_idx <= 0; dump_valid = 0; dump_busy = 0; dump_done = 0.
- clr has priority over a coincident reg_write and over dump_req.

Write port:
- reg_write=1 at a rising edge (clr=0): regs[waddr] <= wdata.
- Register 0 is ordinary storage with no hardwired value.
- Write latency: 1 cycle.

Read ports (combinational, zero latency):
- rdata_x = (reg_write && waddr==raddr_x) ? wdata : regs[raddr_x]. This write-first bypass closes the WB→decode hazard.
- Both ports are independent; both may address the same register.

Dump FSM, states IDLE, SCAN, DONE:
- IDLE: dump_busy=0, dump_valid=0. If dump_req=1, go to SCAN with dump_idx <= 0.
- SCAN: dump_busy=1, dump_valid=1.
  - dump_data = regs[dump_idx], with the same write-first bypass as the read ports, so it reflects a same-cycle write.
  - The beat is accepted when dump_valid && dump_ready.
  - On acceptance with dump_idx < NREGS-1: dump_idx <= dump_idx+1.
  - On acceptance with dump_idx == NREGS-1: go to DONE; dump_idx holds.
  - If dump_ready=0: dump_idx holds and dump_data tracks live register contents (no snapshot).
- DONE: dump_busy=1, dump_valid=0, dump_done=1 for exactly one cycle, then go to IDLE with dump_idx <= 0.
- dump_req is ignored in SCAN and DONE, with no queuing. A dump_req asserted in the IDLE cycle right after DONE starts a new dump.
- Writes and reads stay fully functional during a dump.
- clr in any state aborts the dump immediately. No dump_done is generated for an aborted dump.
- dump_idx is registered. dump_valid, dump_busy and dump_done are decoded from the state register only, and never depend combinationally on dump_ready.

Test Plan:
- Reset: write 0x1234 to r7, then clr=1 for 1 cycle → rdata_a with raddr_a=7 reads 0x0000; dump_busy=0, dump_valid=0.
- Write then read: reg_write, waddr=3, wdata=0xBEEF; next cycle raddr_a=3, raddr_b=3 → both read 0xBEEF. Write to r0 with 0x00FF → r0 reads 0x00FF.
- Bypass and priority: r5=0x0001; same cycle reg_write waddr=5 wdata=0xA5A5, raddr_a=5 → rdata_a=0xA5A5 in that cycle. Separately, clr and reg_write (waddr=2, wdata=0x7777) together → r2=0.
- Full dump with ready=1: preload r[i]=0x0100+i, pulse dump_req → 32 consecutive beats, idx 0..31 with data 0x0100..0x011F, then dump_done high exactly 1 cycle, then dump_busy=0.
- Backpressure: dump_ready toggles 1,0,0,1,… → each index is emitted once in order, dump_idx holds while ready=0, no beat is skipped or duplicated. A write to the held index during a stall shows the new value on dump_data. dump_req pulsed mid-dump has no effect.
- Abort: clr asserted while dump_idx=10 → next cycle dump_valid=0, dump_busy=0, dump_idx=0, no dump_done, all registers 0.
